// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: per-stage register info in,
// stage enables/flushes, forwarding selects and status out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_is_load;
    logic             ex_br_taken;
    logic [4:0]       mem_rd;
    logic             mem_we;
    logic             mem_req;
    logic             mem_ready;
    logic [4:0]       wb_rd;
    logic             wb_we;
    logic             cnt_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_is_load,
               ex_br_taken, mem_rd, mem_we, mem_req, mem_ready, wb_rd, wb_we, cnt_clr,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
               mem_wb_flush, fwd_a, fwd_b, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_is_load,
               ex_br_taken, mem_rd, mem_we, mem_req, mem_ready, wb_rd, wb_we, cnt_clr,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
               mem_wb_flush, fwd_a, fwd_b, mem_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage core: stage enables/flushes, EX forwarding,
// data-memory wait with timeout abort, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic freeze, abort, load_use;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mem_en, ex_mem_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b;

    assign freeze = bus.mem_req && !bus.mem_ready;
    assign abort  = (state_q == StMemWait) && (wait_cnt_q == WaitW'(MEM_TIMEOUT)) && freeze;
    assign load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst_n) begin
            if (abort) begin
                // Drop the stuck access and let the pipeline move on.
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (freeze) begin
                mem_wb_flush = 1'b1;
            end else if (bus.ex_br_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end
    end

    // EX/MEM has the younger result, so it is checked first; x0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (rst_n) begin
            if (bus.mem_we && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs1) fwd_a = 2'b01;
            else if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs1) fwd_a = 2'b10;
            if (bus.mem_we && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs2) fwd_b = 2'b01;
            else if (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs2) fwd_b = 2'b10;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | abort;
        case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (abort || !freeze) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase

        if (bus.cnt_clr) stall_cnt_d = '0;
        else if (!pc_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        else stall_cnt_d = stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a rule-level model of the controller.
module tb_hazard_ctrl;
    localparam int unsigned MemT = 4;
    localparam int unsigned CntW = 4;
    localparam int CntMax = (1 << CntW) - 1;

    localparam logic [7:0] CtrlRun    = 8'b1101_0100;
    localparam logic [7:0] CtrlLu     = 8'b0001_1100;
    localparam logic [7:0] CtrlBr     = 8'b1111_1100;
    localparam logic [7:0] CtrlFreeze = 8'b0000_0001;
    localparam logic [7:0] CtrlAbort  = 8'b1101_0111;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_if #(.CNT_W(CntW)) hif ();

    hazard_ctrl #(.MEM_TIMEOUT(MemT), .CNT_W(CntW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: are we waiting on memory, how many wait cycles so far, error flag, counter.
    bit m_wait   = 1'b0;
    int m_waited = 0;
    bit m_err    = 1'b0;
    int m_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_ctrl();
        return {hif.pc_en, hif.if_id_en, hif.if_id_flush, hif.id_ex_en, hif.id_ex_flush,
                hif.ex_mem_en, hif.ex_mem_flush, hif.mem_wb_flush};
    endfunction

    function automatic bit model_abort();
        return m_wait && m_waited == MemT && !hif.mem_ready;
    endfunction

    function automatic logic [7:0] model_ctrl();
        bit lu;
        lu = hif.ex_is_load && hif.ex_rd != 0 &&
             ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
              (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
        if (!rst_n) return 8'h00;
        if (model_abort()) return CtrlAbort;
        if (hif.mem_req && !hif.mem_ready) return CtrlFreeze;
        if (hif.ex_br_taken) return CtrlBr;
        if (lu) return CtrlLu;
        return CtrlRun;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (!rst_n) return 2'b00;
        if (hif.mem_we && hif.mem_rd != 0 && hif.mem_rd == src) return 2'b01;
        if (hif.wb_we && hif.wb_rd != 0 && hif.wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait   <= 1'b0;
            m_waited <= 0;
            m_err    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            if (hif.cnt_clr) m_cnt <= 0;
            else if (!model_ctrl()[7] && m_cnt < CntMax) m_cnt <= m_cnt + 1;
            if (model_abort()) begin
                m_err    <= 1'b1;
                m_wait   <= 1'b0;
                m_waited <= 0;
            end else if (hif.mem_req && !hif.mem_ready) begin
                m_wait   <= 1'b1;
                m_waited <= m_wait ? m_waited + 1 : 1;
            end else begin
                m_wait   <= 1'b0;
                m_waited <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ctrl", 32'(dut_ctrl()), 32'(model_ctrl()));
        chk("fwd_a", 32'(hif.fwd_a), 32'(model_fwd(hif.ex_rs1)));
        chk("fwd_b", 32'(hif.fwd_b), 32'(model_fwd(hif.ex_rs2)));
        chk("mem_err", 32'(hif.mem_err), 32'(m_err));
        chk("stall_cnt", 32'(hif.stall_cnt), 32'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
        hif.ex_rs1 = 0; hif.ex_rs2 = 0; hif.ex_rd = 0; hif.ex_is_load = 0;
        hif.ex_br_taken = 0; hif.mem_rd = 0; hif.mem_we = 0; hif.mem_req = 0;
        hif.mem_ready = 0; hif.wb_rd = 0; hif.wb_we = 0; hif.cnt_clr = 0;
    endtask

    task automatic drive_load_use();
        hif.ex_rd = 5; hif.ex_is_load = 1; hif.id_rs1 = 5; hif.id_use_rs1 = 1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive_idle();
        #1 rst_n = 1'b0;
        hif.mem_rd = 3; hif.mem_we = 1; hif.ex_rs1 = 3;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'(dut_ctrl()), 32'h0);
        chk("reset_fwd_a", 32'(hif.fwd_a), 32'h0);
        chk("reset_cnt", 32'(hif.stall_cnt), 32'h0);
        chk("reset_err", 32'(hif.mem_err), 32'h0);
        drive_idle();
        rst_n = 1'b1;
        #1 chk("idle_ctrl", 32'(dut_ctrl()), 32'(CtrlRun));
        tick();

        // Load-use bubble, then the load sits in MEM and forwards.
        drive_load_use();
        #1 chk("lu_ctrl", 32'(dut_ctrl()), 32'(CtrlLu));
        tick();
        drive_idle();
        hif.ex_rs1 = 5; hif.mem_rd = 5; hif.mem_we = 1;
        #1 chk("lu_fwd_a", 32'(hif.fwd_a), 32'h1);
        chk("lu_next_ctrl", 32'(dut_ctrl()), 32'(CtrlRun));
        tick();

        drive_idle();
        hif.mem_rd = 7; hif.wb_rd = 7; hif.mem_we = 1; hif.wb_we = 1; hif.ex_rs2 = 7;
        #1 chk("fwd_b_mem", 32'(hif.fwd_b), 32'h1);
        hif.mem_we = 0;
        #1 chk("fwd_b_wb", 32'(hif.fwd_b), 32'h2);
        hif.mem_we = 1; hif.mem_rd = 0; hif.wb_rd = 0; hif.ex_rs2 = 0;
        #1 chk("fwd_b_x0", 32'(hif.fwd_b), 32'h0);
        tick();

        drive_idle();
        drive_load_use();
        hif.ex_br_taken = 1;
        #1 chk("br_over_lu", 32'(dut_ctrl()), 32'(CtrlBr));
        tick();

        // Three-cycle memory wait.
        drive_idle();
        hif.cnt_clr = 1;
        tick();
        hif.cnt_clr = 0;
        #1 chk("clr_cnt", 32'(hif.stall_cnt), 32'h0);
        hif.mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("wait_freeze", 32'(dut_ctrl()), 32'(CtrlFreeze));
            tick();
        end
        hif.mem_ready = 1;
        #1 chk("wait_release", 32'(dut_ctrl()), 32'(CtrlRun));
        tick();
        drive_idle();
        #1 chk("wait_cnt3", 32'(hif.stall_cnt), 32'h3);

        // Timeout: four frozen cycles, then the abort cycle.
        hif.mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_freeze", 32'(dut_ctrl()), 32'(CtrlFreeze));
            tick();
        end
        #1 chk("to_abort", 32'(dut_ctrl()), 32'(CtrlAbort));
        chk("to_err_pre", 32'(hif.mem_err), 32'h0);
        tick();
        drive_idle();
        #1 chk("to_err", 32'(hif.mem_err), 32'h1);
        chk("to_cnt7", 32'(hif.stall_cnt), 32'h7);
        tick();
        chk("err_sticky", 32'(hif.mem_err), 32'h1);

        // Reset in the middle of a wait; afterwards a full wait is needed again.
        hif.mem_req = 1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1 chk("mid_rst_ctrl", 32'(dut_ctrl()), 32'h0);
        chk("mid_rst_cnt", 32'(hif.stall_cnt), 32'h0);
        chk("mid_rst_err", 32'(hif.mem_err), 32'h0);
        rst_n = 1'b1;
        #1 chk("post_rst_freeze", 32'(dut_ctrl()), 32'(CtrlFreeze));
        repeat (4) tick();
        #1 chk("post_rst_abort", 32'(dut_ctrl()), 32'(CtrlAbort));
        tick();
        drive_idle();

        // Saturation, then clear wins over increment.
        hif.cnt_clr = 1;
        tick();
        hif.cnt_clr = 0;
        drive_load_use();
        repeat (20) tick();
        chk("cnt_sat", 32'(hif.stall_cnt), 32'(CntMax));
        hif.cnt_clr = 1;
        tick();
        hif.cnt_clr = 0;
        #1 chk("clr_wins", 32'(hif.stall_cnt), 32'h0);
        drive_idle();
        tick();

        for (int i = 0; i < 3000; i++) begin
            hif.id_rs1      = 5'($urandom_range(0, 3));
            hif.id_rs2      = 5'($urandom_range(0, 3));
            hif.id_use_rs1  = 1'($urandom_range(0, 1));
            hif.id_use_rs2  = 1'($urandom_range(0, 1));
            hif.ex_rs1      = 5'($urandom_range(0, 3));
            hif.ex_rs2      = 5'($urandom_range(0, 3));
            hif.ex_rd       = 5'($urandom_range(0, 3));
            hif.ex_is_load  = 1'($urandom_range(0, 1));
            hif.ex_br_taken = ($urandom_range(0, 4) == 0);
            hif.mem_rd      = 5'($urandom_range(0, 3));
            hif.mem_we      = 1'($urandom_range(0, 1));
            hif.wb_rd       = 5'($urandom_range(0, 3));
            hif.wb_we       = 1'($urandom_range(0, 1));
            hif.mem_req     = m_wait ? 1'b1 : ($urandom_range(0, 5) == 0);
            hif.mem_ready   = ($urandom_range(0, 2) == 0);
            hif.cnt_clr     = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
